// File: rtl/decode_pkg.sv
// decode_pkg
//   Shared types and constants for the decode stage:
//   - RV32I base opcode constants (the nine opcodes the decoder accepts)
//   - write_data / alu_op encodings carried in each micro-op
//   - uop_t: decoded per-lane fields, excluding the PC. The PC width is a
//     parameter of the stage, so each lane slice is laid out as
//     {pc[PC_W-1:0], uop_t} by the modules that use it.
//   - immediate extraction and popcount helpers
package decode_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Register write-back source
  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_PC4 = 2'd2;

  // ALU operation class; the execute stage refines OP/OP-IMM with funct3/funct7
  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_BR    = 2'd1;
  localparam logic [1:0] ALU_OP    = 2'd2;
  localparam logic [1:0] ALU_OPIMM = 2'd3;

  typedef struct packed {
    logic [31:0] imm;
    logic        branch;
    logic        mem_read;
    logic [1:0]  write_data;
    logic [1:0]  alu_op;
    logic        mem_write;
    logic        alu_src_imm;
    logic        reg_write;
    logic        alu_src_pc;
    logic        jump;
    logic [2:0]  load_size;   // {sign_extend, log2(bytes)}
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        illegal;
  } uop_t;

  localparam int UOP_CORE_W = $bits(uop_t);

  function automatic logic [31:0] imm_i(input logic [31:0] insn);
    return {{20{insn[31]}}, insn[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] insn);
    return {{20{insn[31]}}, insn[31:25], insn[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] insn);
    return {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] insn);
    return {insn[31:12], 12'h000};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] insn);
    return {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
  endfunction

  function automatic logic [2:0] popcount4(input logic [3:0] m);
    return 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
  endfunction

endpackage

// File: rtl/decode_lane.sv
// decode_lane
//   Combinational single-instruction decoder for one lane, including the
//   illegal-opcode check and the lane-occupancy mask.
//   Ports:
//     insn_i       raw 32-bit instruction
//     pc_i         PC of this instruction
//     lane_valid_i lane occupied; when 0 every decoded field is forced to 0
//     uop_o        {pc, uop_t} for this lane
module decode_lane
  import decode_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic [31:0]              insn_i,
  input  logic [PC_W-1:0]          pc_i,
  input  logic                     lane_valid_i,
  output logic [PC_W+UOP_CORE_W-1:0] uop_o
);

  uop_t dec;
  logic legal;

  always_comb begin
    dec   = '0;
    legal = 1'b0;
    if (insn_i[1:0] == 2'b11) begin
      legal   = 1'b1;
      dec.rs1 = insn_i[19:15];
      dec.rs2 = insn_i[24:20];
      dec.rd  = insn_i[11:7];
      case (insn_i[6:0])
        OPC_LUI: begin
          // LUI is issued as x0 + imm so the ALU path is shared with AUIPC
          dec.imm         = imm_u(insn_i);
          dec.rs1         = '0;
          dec.alu_src_imm = 1'b1;
          dec.reg_write   = 1'b1;
          dec.alu_op      = ALU_ADD;
          dec.write_data  = WD_ALU;
        end
        OPC_AUIPC: begin
          dec.imm         = imm_u(insn_i);
          dec.alu_src_pc  = 1'b1;
          dec.alu_src_imm = 1'b1;
          dec.reg_write   = 1'b1;
          dec.alu_op      = ALU_ADD;
          dec.write_data  = WD_ALU;
        end
        OPC_JAL: begin
          // ALU forms the target (pc + imm); rd receives pc + 4
          dec.imm         = imm_j(insn_i);
          dec.jump        = 1'b1;
          dec.alu_src_pc  = 1'b1;
          dec.alu_src_imm = 1'b1;
          dec.reg_write   = 1'b1;
          dec.alu_op      = ALU_ADD;
          dec.write_data  = WD_PC4;
        end
        OPC_JALR: begin
          dec.imm         = imm_i(insn_i);
          dec.jump        = 1'b1;
          dec.alu_src_imm = 1'b1;
          dec.reg_write   = 1'b1;
          dec.alu_op      = ALU_ADD;
          dec.write_data  = WD_PC4;
        end
        OPC_BRANCH: begin
          dec.imm    = imm_b(insn_i);
          dec.branch = 1'b1;
          dec.alu_op = ALU_BR;
        end
        OPC_LOAD: begin
          dec.imm         = imm_i(insn_i);
          dec.mem_read    = 1'b1;
          dec.alu_src_imm = 1'b1;
          dec.reg_write   = 1'b1;
          dec.alu_op      = ALU_ADD;
          dec.write_data  = WD_MEM;
          // funct3[2] marks the unsigned variants; low bits give the size
          dec.load_size   = {~insn_i[14], insn_i[13:12]};
        end
        OPC_STORE: begin
          dec.imm         = imm_s(insn_i);
          dec.mem_write   = 1'b1;
          dec.alu_src_imm = 1'b1;
          dec.alu_op      = ALU_ADD;
        end
        OPC_OPIMM: begin
          dec.imm         = imm_i(insn_i);
          dec.alu_src_imm = 1'b1;
          dec.reg_write   = 1'b1;
          dec.alu_op      = ALU_OPIMM;
          dec.write_data  = WD_ALU;
        end
        OPC_OP: begin
          dec.reg_write  = 1'b1;
          dec.alu_op     = ALU_OP;
          dec.write_data = WD_ALU;
        end
        default: legal = 1'b0;
      endcase
    end

    // An illegal instruction carries no side effects, only the flag
    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end

    if (!lane_valid_i) begin
      dec = '0;
    end
  end

  assign uop_o = {pc_i, dec};

endmodule

// File: rtl/decode_stage.sv
// decode_stage
//   Decodes DECODE_WIDTH instructions per cycle and buffers the decoded
//   bundles in a DEPTH-entry circular buffer in front of rename.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     flush           drop all buffered bundles and the current input bundle
//     in_valid/in_ready        fetch-side handshake
//     in_insn, in_pc, in_lane_valid  per-lane instruction, PC, occupancy (lane 0 oldest)
//     out_valid/out_ready      rename-side handshake
//     out_uop         per-lane {pc, uop_t} of the head bundle
//     out_lane_valid  per-lane occupancy of the head bundle
//     out_count       number of occupied lanes in the head bundle
module decode_stage
  import decode_pkg::*;
#(
  parameter int DECODE_WIDTH = 2,
  parameter int DEPTH        = 2,
  parameter int PC_W         = 32,
  localparam int UOP_W       = UOP_CORE_W + PC_W,
  localparam int CNT_W       = $clog2(DECODE_WIDTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DECODE_WIDTH*32-1:0]    in_insn,
  input  logic [DECODE_WIDTH*PC_W-1:0]  in_pc,
  input  logic [DECODE_WIDTH-1:0]       in_lane_valid,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DECODE_WIDTH*UOP_W-1:0] out_uop,
  output logic [DECODE_WIDTH-1:0]       out_lane_valid,
  output logic [CNT_W-1:0]              out_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  logic [DECODE_WIDTH*UOP_W-1:0] dec_bundle;

  // Buffer payload: written on push only, never reset
  logic [DECODE_WIDTH*UOP_W-1:0] buf_uop_q  [DEPTH];
  logic [DECODE_WIDTH-1:0]       buf_mask_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic push, pop;
  logic [3:0] head_mask4;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  for (genvar g = 0; g < DECODE_WIDTH; g++) begin : g_lane
    decode_lane #(
      .PC_W (PC_W)
    ) u_lane (
      .insn_i       (in_insn[g*32 +: 32]),
      .pc_i         (in_pc[g*PC_W +: PC_W]),
      .lane_valid_i (in_lane_valid[g]),
      .uop_o        (dec_bundle[g*UOP_W +: UOP_W])
    );
  end

  // in_ready looks only at occupancy so it never forms a path from out_ready
  assign in_ready  = (count_q < DEPTH_CNT);
  assign out_valid = (count_q != '0);

  // An all-empty bundle is handshaken but not stored
  assign push = in_valid && in_ready && !flush && (in_lane_valid != '0);
  assign pop  = out_valid && out_ready && !flush;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = ptr_inc(tail_q);
      if (pop)  head_d = ptr_inc(head_q);
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_uop_q[tail_q]  <= dec_bundle;
      buf_mask_q[tail_q] <= in_lane_valid;
    end
  end

  // Head entry drives the outputs directly, so they hold while stalled
  assign out_uop        = buf_uop_q[head_q];
  assign out_lane_valid = buf_mask_q[head_q];
  assign head_mask4     = 4'(out_lane_valid);
  assign out_count      = CNT_W'(popcount4(head_mask4));

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter DECODE_WIDTH, default 2: number of instruction lanes decoded per cycle, legal range 1..4.
REQ-002 Parameter DEPTH, default 2: number of decoded bundles buffered, legal range 2..8, power of two.
REQ-003 Parameter PC_W, default 32: program-counter width.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  discard all buffered bundles and the current input bundle.
REQ-007 in_valid  input  1  fetch bundle present.
REQ-008 in_ready  output  1  stage accepts a bundle this cycle.
REQ-009 in_insn  input  DECODE_WIDTH x 32  raw instructions; lane 0 is oldest.
REQ-010 in_pc  input  DECODE_WIDTH x PC_W  per-lane PC.
REQ-011 in_lane_valid  input  DECODE_WIDTH  per-lane occupancy mask.
REQ-012 out_valid  output  1  head bundle present.
REQ-013 out_ready  input  1  downstream (rename) consumes the head bundle.
REQ-014 out_uop  output  DECODE_WIDTH x uop_t  decoded fields: imm[31:0], branch, mem_read, write_data[1:0], alu_op[1:0], mem_write, alu_src_imm, reg_write, alu_src_pc, jump, load_size[2:0], rs1, rs2, rd, pc, illegal.
REQ-015 out_lane_valid  output  DECODE_WIDTH  per-lane occupancy of the head bundle.
REQ-016 out_count  output  $clog2(DECODE_WIDTH+1)  popcount of out_lane_valid.

Function
REQ-017 Each lane SHALL be decoded combinationally by the existing single-instruction decoder; field encodings SHALL be identical to that decoder.
REQ-018 illegal SHALL be 1 when opcode[6:0] is not one of LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, or when insn[1:0] != 2'b11.
REQ-019 A lane with in_lane_valid=0 SHALL be stored with all control fields forced to 0 (reg_write=0, mem_write=0, branch=0, jump=0, illegal=0).
REQ-020 Decoded bundles SHALL be held in a DEPTH-entry circular buffer with head/tail pointers and an occupancy counter of $clog2(DEPTH)+1 bits.
REQ-021 in_ready SHALL equal (count < DEPTH) and SHALL NOT depend combinationally on out_ready or in_valid.
REQ-022 Push SHALL occur when in_valid && in_ready && !flush && (in_lane_valid != 0); a bundle with an all-zero mask SHALL be accepted but dropped.
REQ-023 Pop SHALL occur when out_valid && out_ready && !flush.
REQ-024 out_valid SHALL equal (count != 0); out_uop, out_lane_valid and out_count SHALL come from the head entry, so decode-to-output latency is one cycle minimum.
REQ-025 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-026 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-027 When flush=1, count, head and tail SHALL be 0 on the next edge; out_valid SHALL be 0 from the next cycle; any same-cycle push or pop SHALL be suppressed.
REQ-028 Head-entry outputs SHALL be stable while out_valid && !out_ready.

Reset
REQ-029 On rst_n=0, count, head and tail SHALL clear to 0 asynchronously, giving out_valid=0 and in_ready=1.
REQ-030 Buffer payload storage SHALL NOT be reset.
REQ-031 Reset asserted mid-transfer SHALL discard all buffered bundles.
REQ-032 The first push SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-033 uop_t, the opcode constants and the write_data/alu_op encodings SHALL reside in the shared package decode_pkg.
REQ-034 A single sub-module, decode_lane, SHALL wrap the decoder, the illegal check and the lane mask, and SHALL be instantiated DECODE_WIDTH times in a generate loop.
REQ-035 The buffer SHALL be inline, with no separate FIFO module.

Verification
REQ-036 Reset, then push {addi x1,x0,5 ; lw x2,8(x1)} with mask 11, out_ready=1 -> next cycle out_valid=1, lane0 imm=5 rd=1 reg_write=1, lane1 mem_read=1 write_data=1 load_size=3'b110, out_count=2.
REQ-037 Hold out_ready=0 and push 2 bundles -> in_ready=0 after the second push; a third in_valid is not accepted; outputs stable.
REQ-038 Full buffer, out_ready=1 with in_valid=1 for 8 cycles -> one bundle per cycle in FIFO order across pointer wrap, no loss or duplication.
REQ-039 Push insn 32'h0000_0000 -> illegal=1, reg_write=0; mask 01 -> lane1 all control fields 0, out_count=1.
REQ-040 Flush asserted with 2 buffered bundles and in_valid=1 -> next cycle out_valid=0, count=0, in_ready=1; the flushed input never appears.
REQ-041 Assert rst_n=0 asynchronously mid-stream -> out_valid falls without a clock edge.
